mc_ctrl: RTL and testbench
==========================

# mc_ctrl

Multi-cycle MIPS control unit: a Moore FSM that sequences each instruction over 3–5 clocks and drives the datapath strobes for the shared-memory multi-cycle CPU. It replaces the single-cycle opcode decoder plus ALU-control pair. It adds:
- a memory ready handshake,
- an illegal-opcode flag,
- an instruction-done pulse,
- parametrised field widths.

It sits between the instruction register (op/funct fields) and the datapath muxes, PC, register file and memory port.

## Interface
Parameters:
- OP_W, 6, opcode field width
- FUNCT_W, 6, funct field width
- ALUC_W, 4, ALU control width
- MEM_HANDSHAKE, 1, 1 = memory states wait for mem_ready; 0 = mem_ready ignored (treated as 1)

Ports (one clock; reset is asynchronous and active-low):
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- opcode  in  OP_W  instruction[31:26] from IR
- funct  in  FUNCT_W  instruction[5:0] from IR
- mem_ready  in  1  memory completes the access this cycle
- PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, MemtoReg, RegDst, RegWrite, ALUSrcA  out  1 each  datapath strobes
- ALUSrcB  out  2  00 = B, 01 = const 4, 10 = signext imm, 11 = signext imm<<2
- PCSrc  out  2  00 = ALU result, 01 = ALUOut, 10 = jump target
- ALUCtrl  out  ALUC_W  ALU operation
- illegal_op  out  1  one-cycle pulse on unknown opcode
- instr_done  out  1  one-cycle pulse in the last state of each instruction

## Operation
- States: IDLE, FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, EXEC, ALUWB, BRANCH, JUMP, ADDIEX, ADDIWB.
- All outputs are decoded combinationally from the state register. Unlisted outputs are 0.
- IDLE (reset state): all outputs 0. Goes to FETCH on the next clock.
- FETCH: MemRead=1, IorD=0, ALUSrcA=0, ALUSrcB=01, ALUOp=00, PCSrc=00. IRWrite and PCWrite are 1 only while mem_ready=1. Stays in FETCH while mem_ready=0, then goes to DECODE.
- DECODE: ALUSrcA=0, ALUSrcB=11, ALUOp=00. Next state by opcode:
  - 0x00 → EXEC
  - 0x23 (lw) or 0x2B (sw) → MEMADR
  - 0x04 (beq) → BRANCH
  - 0x02 (j) → JUMP
  - 0x08 (addi) → ADDIEX
  - any other value: illegal_op=1, go to FETCH
- MEMADR: ALUSrcA=1, ALUSrcB=10, ALUOp=00. Goes to MEMRD for lw, MEMWR for sw.
- MEMRD: MemRead=1, IorD=1. Waits for mem_ready, then goes to MEMWB.
- MEMWB: RegWrite=1, MemtoReg=1, RegDst=0, instr_done=1.
- MEMWR: MemWrite=1, IorD=1, waits for mem_ready. instr_done=1 in the cycle mem_ready=1.
- EXEC: ALUSrcA=1, ALUSrcB=00, ALUOp=10. Goes to ALUWB.
- ALUWB: RegWrite=1, RegDst=1, MemtoReg=0, instr_done=1.
- BRANCH: ALUSrcA=1, ALUSrcB=00, ALUOp=01, PCWriteCond=1, PCSrc=01, instr_done=1.
- JUMP: PCWrite=1, PCSrc=10, instr_done=1.
- ADDIEX: ALUSrcA=1, ALUSrcB=10, ALUOp=00. Goes to ADDIWB.
- ADDIWB: RegWrite=1, RegDst=0, MemtoReg=0, instr_done=1.
- Every state carrying instr_done returns to FETCH.
- ALU decode (alu_dec):
  - ALUOp 00 → 0010 (add)
  - ALUOp 01 → 0110 (sub)
  - ALUOp 11 → 0000
  - ALUOp 10 uses funct: 0x20 → 0010, 0x22 → 0110, 0x24 → 0000, 0x25 → 0001, 0x2A → 0111, any other funct → 0010
- ALUCtrl codes are zero-extended to ALUC_W. ALUC_W must be ≥ 4; ALUC_W < 4 is a synthesis error.

## Timing
- Reset assertion forces IDLE asynchronously from any state. All outputs read 0 within the same cycle, even mid-access. The memory strobes drop without waiting for mem_ready.
- After rst_n deasserts: first edge enters IDLE→FETCH, second edge enters FETCH (latched).
- Cycles from FETCH entry to instr_done, with no wait states: R-type 4, lw 5, sw 4, beq 3, j 3, addi 4.
- Each cycle with mem_ready=0 in FETCH, MEMRD or MEMWR adds exactly one cycle. The strobes hold steady throughout.
- When MEM_HANDSHAKE=0, mem_ready is ignored and memory states last 1 cycle.
- opcode and funct are sampled in DECODE and EXEC only. The IR holds them after the FETCH IRWrite.
- illegal_op and instr_done are never high in the same cycle.

## Structure
- Package mc_ctrl_pkg holds:
  - opcode constants: OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_J, OP_ADDI
  - funct constants
  - ALU control codes: ALU_AND, ALU_OR, ALU_ADD, ALU_SUB, ALU_SLT
  - ALUOp codes
  - the state enum (4-bit)
- Sub-module alu_dec: combinational ALUOp/funct → ALUCtrl, parametrised by FUNCT_W and ALUC_W. Reusable by a later pipelined core.

## Test plan
- Reset: hold rst_n=0 for 3 cycles → all outputs 0. After release: IDLE for 1 cycle, then FETCH with MemRead=1, ALUSrcB=01.
- lw (opcode 0x23), mem_ready=1 always → states FETCH, DECODE, MEMADR, MEMRD, MEMWB. instr_done on cycle 5, with RegWrite=1 and MemtoReg=1.
- R-type funct 0x2A → ALUCtrl=0111 in EXEC; ALUWB has RegDst=1. Repeat with funct 0x3F → ALUCtrl=0010.
- beq (0x04) → BRANCH on cycle 3 with PCWriteCond=1, PCSrc=01, ALUCtrl=0110.
- Stalls: sw with mem_ready low for 2 cycles in FETCH and 3 in MEMWR → IRWrite=1 only on the ready cycle, total 9 cycles. MemWrite held for 4 cycles.
- Illegal opcode 0x3F → illegal_op pulse in DECODE, next state FETCH, no RegWrite. Drop rst_n during MEMRD → outputs 0 immediately, restart through IDLE.

Source files
------------

// File: rtl/mc_ctrl_pkg.sv
// Shared constants and types for the multi-cycle MIPS control unit.
package mc_ctrl_pkg;

   // Primary opcodes (instruction[31:26])
   localparam logic [5:0] OP_RTYPE = 6'h00;
   localparam logic [5:0] OP_LW    = 6'h23;
   localparam logic [5:0] OP_SW    = 6'h2B;
   localparam logic [5:0] OP_BEQ   = 6'h04;
   localparam logic [5:0] OP_J     = 6'h02;
   localparam logic [5:0] OP_ADDI  = 6'h08;

   // R-type function codes (instruction[5:0])
   localparam logic [5:0] FN_ADD = 6'h20;
   localparam logic [5:0] FN_SUB = 6'h22;
   localparam logic [5:0] FN_AND = 6'h24;
   localparam logic [5:0] FN_OR  = 6'h25;
   localparam logic [5:0] FN_SLT = 6'h2A;

   // ALU operation codes seen by the datapath ALU
   localparam logic [3:0] ALU_AND = 4'b0000;
   localparam logic [3:0] ALU_OR  = 4'b0001;
   localparam logic [3:0] ALU_ADD = 4'b0010;
   localparam logic [3:0] ALU_SUB = 4'b0110;
   localparam logic [3:0] ALU_SLT = 4'b0111;

   // ALUOp encodings from the FSM to the ALU decoder
   localparam logic [1:0] ALUOP_ADD   = 2'b00;
   localparam logic [1:0] ALUOP_SUB   = 2'b01;
   localparam logic [1:0] ALUOP_FUNCT = 2'b10;
   localparam logic [1:0] ALUOP_AND   = 2'b11;

   typedef enum logic [3:0] {
      S_IDLE   = 4'd0,
      S_FETCH  = 4'd1,
      S_DECODE = 4'd2,
      S_MEMADR = 4'd3,
      S_MEMRD  = 4'd4,
      S_MEMWB  = 4'd5,
      S_MEMWR  = 4'd6,
      S_EXEC   = 4'd7,
      S_ALUWB  = 4'd8,
      S_BRANCH = 4'd9,
      S_JUMP   = 4'd10,
      S_ADDIEX = 4'd11,
      S_ADDIWB = 4'd12
   } state_t;

endpackage

// File: rtl/mc_ctrl_alu_dec.sv
// ALU decoder: maps ALUOp plus R-type funct to the ALU operation code.
// Purely combinational so a pipelined core can reuse it unchanged.
module alu_dec
   import mc_ctrl_pkg::*;
#(
   parameter int FUNCT_W = 6,
   parameter int ALUC_W  = 4
) (
   input  logic [1:0]         aluop,
   input  logic [FUNCT_W-1:0] funct,
   output logic [ALUC_W-1:0]  aluctrl
);

   logic [3:0] code_s;

   // The ALU codes are 4 bits wide; a narrower port cannot carry them.
   if (ALUC_W < 4) begin : g_aluc_w_check
      $error("alu_dec: ALUC_W must be at least 4");
   end

   // Select the 4-bit ALU code from ALUOp, consulting funct only for R-type.
   always_comb begin
      code_s = ALU_ADD;
      case (aluop)
         ALUOP_ADD: code_s = ALU_ADD;
         ALUOP_SUB: code_s = ALU_SUB;
         ALUOP_AND: code_s = ALU_AND;
         ALUOP_FUNCT: begin
            case (funct)
               FUNCT_W'(FN_ADD): code_s = ALU_ADD;
               FUNCT_W'(FN_SUB): code_s = ALU_SUB;
               FUNCT_W'(FN_AND): code_s = ALU_AND;
               FUNCT_W'(FN_OR):  code_s = ALU_OR;
               FUNCT_W'(FN_SLT): code_s = ALU_SLT;
               default:          code_s = ALU_ADD;
            endcase
         end
         default: code_s = ALU_ADD;
      endcase
   end

   assign aluctrl = ALUC_W'(code_s);

endmodule

// File: rtl/mc_ctrl.sv
// Multi-cycle MIPS control unit. A Moore FSM sequences each instruction
// over 3-5 clocks; the datapath strobes decode from the state register,
// with only the memory-completion strobes gated by mem_ready.
module mc_ctrl
   import mc_ctrl_pkg::*;
#(
   parameter int OP_W          = 6,
   parameter int FUNCT_W       = 6,
   parameter int ALUC_W        = 4,
   parameter int MEM_HANDSHAKE = 1
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic [OP_W-1:0]    opcode,
   input  logic [FUNCT_W-1:0] funct,
   input  logic               mem_ready,
   output logic               PCWrite,
   output logic               PCWriteCond,
   output logic               IorD,
   output logic               MemRead,
   output logic               MemWrite,
   output logic               IRWrite,
   output logic               MemtoReg,
   output logic               RegDst,
   output logic               RegWrite,
   output logic               ALUSrcA,
   output logic [1:0]         ALUSrcB,
   output logic [1:0]         PCSrc,
   output logic [ALUC_W-1:0]  ALUCtrl,
   output logic               illegal_op,
   output logic               instr_done
);

   state_t     state_r;
   logic       is_sw_r;
   logic       rdy_s;
   logic       op_known_s;
   logic [1:0] aluop_s;

   // Without the handshake every memory access completes in one cycle.
   assign rdy_s = (MEM_HANDSHAKE != 0) ? mem_ready : 1'b1;

   // Classify the opcode so DECODE can flag anything it cannot sequence.
   always_comb begin
      op_known_s = 1'b0;
      case (opcode)
         OP_W'(OP_RTYPE): op_known_s = 1'b1;
         OP_W'(OP_LW):    op_known_s = 1'b1;
         OP_W'(OP_SW):    op_known_s = 1'b1;
         OP_W'(OP_BEQ):   op_known_s = 1'b1;
         OP_W'(OP_J):     op_known_s = 1'b1;
         OP_W'(OP_ADDI):  op_known_s = 1'b1;
         default:         op_known_s = 1'b0;
      endcase
   end

   // State sequencing; lw/sw is remembered in DECODE because the opcode
   // is only guaranteed stable there.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r <= S_IDLE;
         is_sw_r <= 1'b0;
      end else begin
         case (state_r)
            S_IDLE:   state_r <= S_FETCH;
            S_FETCH:  state_r <= rdy_s ? S_DECODE : S_FETCH;
            S_DECODE: begin
               is_sw_r <= (opcode == OP_W'(OP_SW));
               case (opcode)
                  OP_W'(OP_RTYPE): state_r <= S_EXEC;
                  OP_W'(OP_LW):    state_r <= S_MEMADR;
                  OP_W'(OP_SW):    state_r <= S_MEMADR;
                  OP_W'(OP_BEQ):   state_r <= S_BRANCH;
                  OP_W'(OP_J):     state_r <= S_JUMP;
                  OP_W'(OP_ADDI):  state_r <= S_ADDIEX;
                  default:         state_r <= S_FETCH;
               endcase
            end
            S_MEMADR: state_r <= is_sw_r ? S_MEMWR : S_MEMRD;
            S_MEMRD:  state_r <= rdy_s ? S_MEMWB : S_MEMRD;
            S_MEMWR:  state_r <= rdy_s ? S_FETCH : S_MEMWR;
            S_EXEC:   state_r <= S_ALUWB;
            S_ADDIEX: state_r <= S_ADDIWB;
            S_MEMWB:  state_r <= S_FETCH;
            S_ALUWB:  state_r <= S_FETCH;
            S_BRANCH: state_r <= S_FETCH;
            S_JUMP:   state_r <= S_FETCH;
            S_ADDIWB: state_r <= S_FETCH;
            default:  state_r <= S_IDLE;
         endcase
      end
   end

   // Datapath strobes per state. States that do not use the ALU select
   // ALUOp 11 so ALUCtrl reads 0000 like every other idle strobe.
   always_comb begin
      PCWrite     = 1'b0;
      PCWriteCond = 1'b0;
      IorD        = 1'b0;
      MemRead     = 1'b0;
      MemWrite    = 1'b0;
      IRWrite     = 1'b0;
      MemtoReg    = 1'b0;
      RegDst      = 1'b0;
      RegWrite    = 1'b0;
      ALUSrcA     = 1'b0;
      ALUSrcB     = 2'b00;
      PCSrc       = 2'b00;
      illegal_op  = 1'b0;
      instr_done  = 1'b0;
      aluop_s     = ALUOP_AND;
      case (state_r)
         S_FETCH: begin
            MemRead = 1'b1;
            ALUSrcB = 2'b01;
            aluop_s = ALUOP_ADD;
            IRWrite = rdy_s;
            PCWrite = rdy_s;
         end
         S_DECODE: begin
            ALUSrcB    = 2'b11;
            aluop_s    = ALUOP_ADD;
            illegal_op = ~op_known_s;
         end
         S_MEMADR: begin
            ALUSrcA = 1'b1;
            ALUSrcB = 2'b10;
            aluop_s = ALUOP_ADD;
         end
         S_MEMRD: begin
            MemRead = 1'b1;
            IorD    = 1'b1;
         end
         S_MEMWB: begin
            RegWrite   = 1'b1;
            MemtoReg   = 1'b1;
            instr_done = 1'b1;
         end
         S_MEMWR: begin
            MemWrite   = 1'b1;
            IorD       = 1'b1;
            instr_done = rdy_s;
         end
         S_EXEC: begin
            ALUSrcA = 1'b1;
            aluop_s = ALUOP_FUNCT;
         end
         S_ALUWB: begin
            RegWrite   = 1'b1;
            RegDst     = 1'b1;
            instr_done = 1'b1;
         end
         S_BRANCH: begin
            ALUSrcA     = 1'b1;
            aluop_s     = ALUOP_SUB;
            PCWriteCond = 1'b1;
            PCSrc       = 2'b01;
            instr_done  = 1'b1;
         end
         S_JUMP: begin
            PCWrite    = 1'b1;
            PCSrc      = 2'b10;
            instr_done = 1'b1;
         end
         S_ADDIEX: begin
            ALUSrcA = 1'b1;
            ALUSrcB = 2'b10;
            aluop_s = ALUOP_ADD;
         end
         S_ADDIWB: begin
            RegWrite   = 1'b1;
            instr_done = 1'b1;
         end
         default: begin
            aluop_s = ALUOP_AND;
         end
      endcase
   end

   alu_dec #(
      .FUNCT_W (FUNCT_W),
      .ALUC_W  (ALUC_W)
   ) u_alu_dec (
      .aluop   (aluop_s),
      .funct   (funct),
      .aluctrl (ALUCtrl)
   );

endmodule

// File: tb/tb_mc_ctrl.sv
// Directed bench for mc_ctrl: per-cycle vector table plus hand-written
// reset and no-handshake sequences.
module tb_mc_ctrl;

   // Output bundle bit order:
   // [19]PCWrite [18]PCWriteCond [17]IorD [16]MemRead [15]MemWrite
   // [14]IRWrite [13]MemtoReg [12]RegDst [11]RegWrite [10]ALUSrcA
   // [9:8]ALUSrcB [7:6]PCSrc [5:2]ALUCtrl [1]illegal_op [0]instr_done
   localparam logic [19:0] E_ZERO     = 20'h00000;
   localparam logic [19:0] E_FETCH    = 20'h94108;
   localparam logic [19:0] E_FETCH_ST = 20'h10108;
   localparam logic [19:0] E_DECODE   = 20'h00308;
   localparam logic [19:0] E_ILLEGAL  = 20'h0030A;
   localparam logic [19:0] E_MEMADR   = 20'h00608;
   localparam logic [19:0] E_MEMRD    = 20'h30000;
   localparam logic [19:0] E_MEMWB    = 20'h02801;
   localparam logic [19:0] E_MEMWR    = 20'h28001;
   localparam logic [19:0] E_MEMWR_ST = 20'h28000;
   localparam logic [19:0] E_EXEC_SLT = 20'h0041C;
   localparam logic [19:0] E_EXEC_ADD = 20'h00408;
   localparam logic [19:0] E_EXEC_AND = 20'h00400;
   localparam logic [19:0] E_EXEC_OR  = 20'h00404;
   localparam logic [19:0] E_EXEC_SUB = 20'h00418;
   localparam logic [19:0] E_ALUWB    = 20'h01801;
   localparam logic [19:0] E_BRANCH   = 20'h40459;
   localparam logic [19:0] E_JUMP     = 20'h80081;
   localparam logic [19:0] E_ADDIEX   = 20'h00608;
   localparam logic [19:0] E_ADDIWB   = 20'h00801;

   typedef struct {
      string       name;
      logic [5:0]  op;
      logic [5:0]  fn;
      logic        rdy;
      logic [19:0] exp;
   } vec_t;

   logic        clk;
   logic        rst_n, rst2_n;
   logic [5:0]  opcode, funct, op2, funct2;
   logic        mem_ready, rdy2;
   logic [19:0] o1, o2;
   int          checks, errors;
   vec_t        tbl[$];

   mc_ctrl u_dut (
      .clk(clk), .rst_n(rst_n), .opcode(opcode), .funct(funct), .mem_ready(mem_ready),
      .PCWrite(o1[19]), .PCWriteCond(o1[18]), .IorD(o1[17]), .MemRead(o1[16]),
      .MemWrite(o1[15]), .IRWrite(o1[14]), .MemtoReg(o1[13]), .RegDst(o1[12]),
      .RegWrite(o1[11]), .ALUSrcA(o1[10]), .ALUSrcB(o1[9:8]), .PCSrc(o1[7:6]),
      .ALUCtrl(o1[5:2]), .illegal_op(o1[1]), .instr_done(o1[0])
   );

   mc_ctrl #(.MEM_HANDSHAKE(0)) u_dut_nh (
      .clk(clk), .rst_n(rst2_n), .opcode(op2), .funct(funct2), .mem_ready(rdy2),
      .PCWrite(o2[19]), .PCWriteCond(o2[18]), .IorD(o2[17]), .MemRead(o2[16]),
      .MemWrite(o2[15]), .IRWrite(o2[14]), .MemtoReg(o2[13]), .RegDst(o2[12]),
      .RegWrite(o2[11]), .ALUSrcA(o2[10]), .ALUSrcB(o2[9:8]), .PCSrc(o2[7:6]),
      .ALUCtrl(o2[5:2]), .illegal_op(o2[1]), .instr_done(o2[0])
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout required completion");
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string nm, input logic [19:0] act, input logic [19:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %05h expected %05h", nm, act, exp);
      end
   endtask

   task automatic add(input string nm, input logic [5:0] op, input logic [5:0] fn,
                      input logic rdy, input logic [19:0] ex);
      vec_t v;
      v.name = nm; v.op = op; v.fn = fn; v.rdy = rdy; v.exp = ex;
      tbl.push_back(v);
   endtask

   task automatic step(input vec_t v);
      opcode    = v.op;
      funct     = v.fn;
      mem_ready = v.rdy;
      @(negedge clk);
      check(v.name, o1, v.exp);
      @(posedge clk);
      #1;
   endtask

   initial begin
      logic [19:0] nh_exp [6];
      vec_t v;
      checks = 0;
      errors = 0;
      rst_n = 1'b1; rst2_n = 1'b1;
      opcode = 6'h00; funct = 6'h00; mem_ready = 1'b0;
      op2 = 6'h2B; funct2 = 6'h00; rdy2 = 1'b0;

      // lw, no wait states: 5 cycles
      add("lw_fetch",  6'h23, 6'h00, 1'b1, E_FETCH);
      add("lw_decode", 6'h23, 6'h00, 1'b1, E_DECODE);
      add("lw_memadr", 6'h23, 6'h00, 1'b1, E_MEMADR);
      add("lw_memrd",  6'h23, 6'h00, 1'b1, E_MEMRD);
      add("lw_memwb",  6'h23, 6'h00, 1'b1, E_MEMWB);
      // R-type slt, then unknown funct
      add("slt_fetch",  6'h00, 6'h2A, 1'b1, E_FETCH);
      add("slt_decode", 6'h00, 6'h2A, 1'b1, E_DECODE);
      add("slt_exec",   6'h00, 6'h2A, 1'b1, E_EXEC_SLT);
      add("slt_aluwb",  6'h00, 6'h2A, 1'b1, E_ALUWB);
      add("f3f_fetch",  6'h00, 6'h3F, 1'b1, E_FETCH);
      add("f3f_decode", 6'h00, 6'h3F, 1'b1, E_DECODE);
      add("f3f_exec",   6'h00, 6'h3F, 1'b1, E_EXEC_ADD);
      add("f3f_aluwb",  6'h00, 6'h3F, 1'b1, E_ALUWB);
      // and / or / sub funct decode (funct changes only matter in EXEC)
      add("and_fetch",  6'h00, 6'h24, 1'b1, E_FETCH);
      add("and_decode", 6'h00, 6'h24, 1'b1, E_DECODE);
      add("and_exec",   6'h00, 6'h24, 1'b1, E_EXEC_AND);
      add("or_aluwb",   6'h00, 6'h25, 1'b1, E_ALUWB);
      add("or_fetch",   6'h00, 6'h25, 1'b1, E_FETCH);
      add("or_decode",  6'h00, 6'h25, 1'b1, E_DECODE);
      add("or_exec",    6'h00, 6'h25, 1'b1, E_EXEC_OR);
      add("sub_aluwb",  6'h00, 6'h22, 1'b1, E_ALUWB);
      add("sub_fetch",  6'h00, 6'h22, 1'b1, E_FETCH);
      add("sub_decode", 6'h00, 6'h22, 1'b1, E_DECODE);
      add("sub_exec",   6'h00, 6'h22, 1'b1, E_EXEC_SUB);
      add("sub_aluwb2", 6'h00, 6'h22, 1'b1, E_ALUWB);
      // beq: 3 cycles
      add("beq_fetch",  6'h04, 6'h00, 1'b1, E_FETCH);
      add("beq_decode", 6'h04, 6'h00, 1'b1, E_DECODE);
      add("beq_branch", 6'h04, 6'h00, 1'b1, E_BRANCH);
      // j: 3 cycles
      add("j_fetch",    6'h02, 6'h00, 1'b1, E_FETCH);
      add("j_decode",   6'h02, 6'h00, 1'b1, E_DECODE);
      add("j_jump",     6'h02, 6'h00, 1'b1, E_JUMP);
      // addi: 4 cycles
      add("addi_fetch",  6'h08, 6'h00, 1'b1, E_FETCH);
      add("addi_decode", 6'h08, 6'h00, 1'b1, E_DECODE);
      add("addi_ex",     6'h08, 6'h00, 1'b1, E_ADDIEX);
      add("addi_wb",     6'h08, 6'h00, 1'b1, E_ADDIWB);
      // sw with 2 FETCH and 3 MEMWR stalls: 9 cycles; opcode disturbed
      // after DECODE must not change the path
      add("sw_fetch_st1", 6'h2B, 6'h00, 1'b0, E_FETCH_ST);
      add("sw_fetch_st2", 6'h2B, 6'h00, 1'b0, E_FETCH_ST);
      add("sw_fetch_rdy", 6'h2B, 6'h00, 1'b1, E_FETCH);
      add("sw_decode",    6'h2B, 6'h00, 1'b1, E_DECODE);
      add("sw_memadr",    6'h23, 6'h00, 1'b1, E_MEMADR);
      add("sw_memwr_st1", 6'h23, 6'h00, 1'b0, E_MEMWR_ST);
      add("sw_memwr_st2", 6'h23, 6'h00, 1'b0, E_MEMWR_ST);
      add("sw_memwr_st3", 6'h23, 6'h00, 1'b0, E_MEMWR_ST);
      add("sw_memwr_rdy", 6'h23, 6'h00, 1'b1, E_MEMWR);
      // illegal opcode then straight back to FETCH
      add("ill_fetch",    6'h3F, 6'h00, 1'b1, E_FETCH);
      add("ill_decode",   6'h3F, 6'h00, 1'b1, E_ILLEGAL);
      add("ill_refetch",  6'h23, 6'h00, 1'b1, E_FETCH);
      // lw with one MEMRD stall
      add("lws_decode",   6'h23, 6'h00, 1'b1, E_DECODE);
      add("lws_memadr",   6'h23, 6'h00, 1'b1, E_MEMADR);
      add("lws_memrd_st", 6'h23, 6'h00, 1'b0, E_MEMRD);
      add("lws_memrd",    6'h23, 6'h00, 1'b1, E_MEMRD);
      add("lws_memwb",    6'h23, 6'h00, 1'b1, E_MEMWB);

      // Reset held for 3 cycles: everything reads 0
      #2;
      rst_n = 1'b0; rst2_n = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("reset_hold", o1, E_ZERO);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      opcode = 6'h23; mem_ready = 1'b1;
      @(negedge clk);
      check("idle_after_release", o1, E_ZERO);
      @(posedge clk);
      #1;

      foreach (tbl[i]) step(tbl[i]);

      // Reset dropped mid-MEMRD with the memory still busy
      v.fn = 6'h00; v.op = 6'h23; v.rdy = 1'b1;
      v.name = "mr_fetch";  v.exp = E_FETCH;  step(v);
      v.name = "mr_decode"; v.exp = E_DECODE; step(v);
      v.name = "mr_memadr"; v.exp = E_MEMADR; step(v);
      mem_ready = 1'b0;
      @(negedge clk);
      check("mr_memrd", o1, E_MEMRD);
      #2;
      rst_n = 1'b0;
      #1;
      check("mr_async_reset", o1, E_ZERO);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      @(negedge clk);
      check("mr_idle", o1, E_ZERO);
      @(posedge clk);
      #1;
      @(negedge clk);
      check("mr_fetch_stall", o1, E_FETCH_ST);
      mem_ready = 1'b1;
      #1;
      check("mr_fetch_ready", o1, E_FETCH);

      // No-handshake variant: sw with mem_ready stuck low still completes
      nh_exp[0] = E_ZERO;
      nh_exp[1] = E_FETCH;
      nh_exp[2] = E_DECODE;
      nh_exp[3] = E_MEMADR;
      nh_exp[4] = E_MEMWR;
      nh_exp[5] = E_FETCH;
      @(posedge clk);
      #1;
      rst2_n = 1'b1;
      for (int k = 0; k < 6; k++) begin
         @(negedge clk);
         check($sformatf("nohs_cycle%0d", k), o2, nh_exp[k]);
         @(posedge clk);
         #1;
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
